// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
// Contents:
//   ps_state_e  - FSM state encoding (IDLE, HIGH, GAP)
//   max_u       - maximum of two unsigned ints, usable in constant expressions
//   cnt_width   - width of the shared HIGH/GAP down-counter
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } ps_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to hold the larger of the two reload values; never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned high_c, input int unsigned gap_c);
    int unsigned w;
    w = $clog2(max_u(high_c, gap_c) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter used to time the HIGH and GAP phases.
// Ports:
//   clk_i       - clock, rising edge
//   reset_n_i   - asynchronous active-low reset (counter clears to 0)
//   load_i      - load load_val_i (has priority over en_i)
//   load_val_i  - value to load
//   en_i        - decrement by one when nonzero
//   zero_o      - count is zero
module cycle_down_counter #(
  parameter int unsigned width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               en_i,
  output logic               zero_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into level windows of high_cycles_p cycles, each
// followed by at least gap_cycles_p low cycles.
// Optional feature macro: PULSE_STRETCHER_PENDING_EN
//   defined   - events arriving while busy are queued in a saturating pending counter
//   undefined - events arriving while busy are discarded; pending_o is tied to 0
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - asynchronous active-low reset
//   pulse_i    - event strobe; each high cycle is one event
//   level_o    - stretched level (registered)
//   busy_o     - high in HIGH or GAP (registered)
//   pending_o  - queued events not yet output (registered)
//   dropped_o  - one-cycle strobe, an event was discarded (registered)
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned high_cycles_p = 4,
  parameter int unsigned gap_cycles_p  = 2,
  parameter int unsigned pending_max_p = 7,
  localparam int unsigned PendW = (pending_max_p > 0) ? $clog2(pending_max_p + 1) : 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             pulse_i,
  output logic             level_o,
  output logic             busy_o,
  output logic [PendW-1:0] pending_o,
  output logic             dropped_o
);

  localparam int unsigned CntW = cnt_width(high_cycles_p, gap_cycles_p);
  // Counter runs reload..0, so reload is one less than the phase length.
  localparam logic [CntW-1:0] HighLoad = CntW'(high_cycles_p - 1);
  localparam logic [CntW-1:0] GapLoad  = (gap_cycles_p > 0) ? CntW'(gap_cycles_p - 1) : '0;

  ps_state_e       state_q, state_d;
  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_en;
  logic            cnt_zero;
  logic            end_gap;
  logic            busy;
  logic            pending_nz;
  logic            drop_d;
  logic            level_q, busy_q, drop_q;

  assign busy = (state_q != IDLE);

  cycle_down_counter #(
    .width_p (CntW)
  ) u_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = HighLoad;
    cnt_en       = 1'b0;
    end_gap      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pulse_i) begin
          state_d  = HIGH;
          cnt_load = 1'b1;
        end
      end
      HIGH: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          if (gap_cycles_p > 0) begin
            state_d      = GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GapLoad;
          end else begin
            end_gap = 1'b1;
          end
        end
      end
      GAP: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          end_gap = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Restart straight into HIGH so queued or coincident events lose no cycle in IDLE.
    if (end_gap) begin
      if (pending_nz || pulse_i) begin
        state_d      = HIGH;
        cnt_load     = 1'b1;
        cnt_load_val = HighLoad;
      end else begin
        state_d = IDLE;
      end
    end
  end

`ifdef PULSE_STRETCHER_PENDING_EN
  localparam logic [PendW-1:0] PendMax = PendW'(pending_max_p);

  logic [PendW-1:0] pending_q, pending_d;
  logic             pend_inc, pend_dec;

  always_comb begin
    // A pulse at end-of-GAP with nothing queued starts the window itself.
    pend_inc  = busy && pulse_i && !(end_gap && (pending_q == '0));
    pend_dec  = end_gap && (pending_q != '0);
    pending_d = pending_q;
    drop_d    = 1'b0;
    if (pend_inc && !pend_dec) begin
      if (pending_q == PendMax) begin
        drop_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (pend_dec && !pend_inc) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_nz = (pending_q != '0);
  assign pending_o  = pending_q;
`else
  always_comb begin
    drop_d = busy && pulse_i && !end_gap;
  end

  assign pending_nz = 1'b0;
  assign pending_o  = '0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      drop_q  <= drop_d;
    end
  end

  assign level_o   = level_q;
  assign busy_o    = busy_q;
  assign dropped_o = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (high=4, gap=2, max=7).
// Cycle c is the interval whose outputs are sampled at the c-th falling edge after reset
// release; a pulse driven in cycle c is captured on the rising edge that ends it.
module tb_pulse_stretcher;

  localparam int unsigned PW = 3;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          pulse_i;
  logic          level_o;
  logic          busy_o;
  logic [PW-1:0] pending_o;
  logic          dropped_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [127:0] lvl_v, busy_v, drop_v, pnz_v;
  int           pend_a [128];
  logic [127:0] exp_v;

  always #5 clk_i = ~clk_i;

  pulse_stretcher #(
    .high_cycles_p (4),
    .gap_cycles_p  (2),
    .pending_max_p (7)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .pulse_i   (pulse_i),
    .level_o   (level_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .dropped_o (dropped_o)
  );

  function automatic logic [127:0] mask(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk_int(input string tag, input int got, input int exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    pulse_i   = 1'b0;
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic run_seq(input logic [127:0] pat, input int n);
    lvl_v  = '0;
    busy_v = '0;
    drop_v = '0;
    pnz_v  = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      lvl_v[c]  = level_o;
      busy_v[c] = busy_o;
      drop_v[c] = dropped_o;
      pnz_v[c]  = |pending_o;
      pend_a[c] = int'(pending_o);
      pulse_i   = pat[c];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pulse_i   = 1'b0;
    reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1;
    chk_int("rst_level", int'(level_o), 0);
    chk_int("rst_busy", int'(busy_o), 0);
    chk_int("rst_pending", int'(pending_o), 0);
    chk_int("rst_dropped", int'(dropped_o), 0);

    // Single pulse at 10: high 11-14, gap 15-16, idle from 17.
    do_reset();
    run_seq(mask(10, 10), 30);
    chk_vec("t1_level", lvl_v, mask(11, 14));
    chk_vec("t1_busy", busy_v, mask(11, 16));
    chk_vec("t1_drop", drop_v, '0);
    chk_vec("t1_pending", pnz_v, '0);

    // Pulse in last GAP cycle with nothing queued: straight back to HIGH at 17.
    do_reset();
    run_seq(mask(10, 10) | mask(16, 16), 35);
    chk_vec("t4a_level", lvl_v, mask(11, 14) | mask(17, 20));
    chk_vec("t4a_busy", busy_v, mask(11, 22));
    chk_vec("t4a_drop", drop_v, '0);
    chk_vec("t4a_pending", pnz_v, '0);

`ifdef PULSE_STRETCHER_PENDING_EN
    // Pulses at 10, 12, 13: pending 1 then 2, three windows.
    do_reset();
    run_seq(mask(10, 10) | mask(12, 13), 35);
    chk_vec("t2_level", lvl_v, mask(11, 14) | mask(17, 20) | mask(23, 26));
    chk_vec("t2_busy", busy_v, mask(11, 28));
    chk_vec("t2_drop", drop_v, '0);
    chk_int("t2_pend12", pend_a[12], 0);
    chk_int("t2_pend13", pend_a[13], 1);
    chk_int("t2_pend14", pend_a[14], 2);
    chk_int("t2_pend16", pend_a[16], 2);
    chk_int("t2_pend17", pend_a[17], 1);
    chk_int("t2_pend22", pend_a[22], 1);
    chk_int("t2_pend23", pend_a[23], 0);

    // Pulse held 10-21. Busy events 11-15 queue (5), 16 queues+consumes, 17-18 reach 7,
    // 19-21 are dropped (strobes 20-22). Windows: 11, 17, then 7 from the queue = 9.
    do_reset();
    run_seq(mask(10, 21), 75);
    exp_v = '0;
    for (int k = 0; k < 9; k++) exp_v = exp_v | mask(11 + 6 * k, 14 + 6 * k);
    chk_vec("t3_level", lvl_v, exp_v);
    chk_vec("t3_busy", busy_v, mask(11, 64));
    chk_vec("t3_drop", drop_v, mask(20, 22));
    chk_int("t3_pend16", pend_a[16], 5);
    chk_int("t3_pend17", pend_a[17], 5);
    chk_int("t3_pend19", pend_a[19], 7);
    chk_int("t3_pend22", pend_a[22], 7);
    chk_int("t3_pend23", pend_a[23], 6);
    chk_int("t3_pend65", pend_a[65], 0);

    // Pending 3, pulse in last GAP cycle: HIGH at 17 and pending stays 3.
    do_reset();
    run_seq(mask(10, 13) | mask(16, 16), 50);
    chk_int("t4b_pend16", pend_a[16], 3);
    chk_int("t4b_pend17", pend_a[17], 3);
    chk_vec("t4b_level", lvl_v,
            mask(11, 14) | mask(17, 20) | mask(23, 26) | mask(29, 32) | mask(35, 38));
    chk_vec("t4b_busy", busy_v, mask(11, 40));
    chk_vec("t4b_drop", drop_v, '0);

    // Reset in cycle 13 (mid-HIGH, pending 2) clears everything at once.
    do_reset();
    run_seq(mask(10, 12), 14);
    chk_int("t5_pre_level", int'(level_o), 1);
    chk_int("t5_pre_pending", int'(pending_o), 2);
    #1 reset_n_i = 1'b0;
    #1;
    chk_int("t5_level", int'(level_o), 0);
    chk_int("t5_busy", int'(busy_o), 0);
    chk_int("t5_pending", int'(pending_o), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    run_seq('0, 20);
    chk_vec("t5_post_level", lvl_v, '0);
    chk_vec("t5_post_busy", busy_v, '0);
    chk_vec("t5_post_pending", pnz_v, '0);
`else
    // Pulses at 10 and 13: second is discarded, strobe at 14.
    do_reset();
    run_seq(mask(10, 10) | mask(13, 13), 30);
    chk_vec("t6_level", lvl_v, mask(11, 14));
    chk_vec("t6_busy", busy_v, mask(11, 16));
    chk_vec("t6_drop", drop_v, mask(14, 14));
    chk_vec("t6_pending", pnz_v, '0);

    // Pulse during GAP (15, not last GAP cycle) is discarded, strobe at 16.
    do_reset();
    run_seq(mask(10, 10) | mask(15, 15), 30);
    chk_vec("gap_drop_level", lvl_v, mask(11, 14));
    chk_vec("gap_drop_drop", drop_v, mask(16, 16));

    // Pulse held 10-16: 11-15 discarded (strobes 12-16), 16 restarts the window.
    do_reset();
    run_seq(mask(10, 16), 35);
    chk_vec("held_level", lvl_v, mask(11, 14) | mask(17, 20));
    chk_vec("held_busy", busy_v, mask(11, 22));
    chk_vec("held_drop", drop_v, mask(12, 16));
    chk_vec("held_pending", pnz_v, '0);

    // Reset in cycle 12 (mid-HIGH, drop strobe showing) clears everything at once.
    do_reset();
    run_seq(mask(10, 11), 13);
    chk_int("t5_pre_level", int'(level_o), 1);
    chk_int("t5_pre_drop", int'(dropped_o), 1);
    #1 reset_n_i = 1'b0;
    #1;
    chk_int("t5_level", int'(level_o), 0);
    chk_int("t5_busy", int'(busy_o), 0);
    chk_int("t5_dropped", int'(dropped_o), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    run_seq('0, 20);
    chk_vec("t5_post_level", lvl_v, '0);
    chk_vec("t5_post_busy", busy_v, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
